imem_fetch_ctrl: RTL
====================

// Module: imem_fetch_ctrl
// PURPOSE
//  Instruction-fetch controller between the CPU's PC/INSTRUCTION interface and a byte-wide, variable-latency instruction memory.
//  Sequences four byte reads per instruction and assembles them little-endian (byte at base+0 -> INSTRUCTION[7:0]).
//  Stalls the CPU via BUSYWAIT until the word for the current PC is valid.
//  Restarts the fetch on PC redirects (beq/j) and flags hung memory.
// PARAMETERS
//  ADDR_W   10   instruction memory byte-address width (1024 bytes); PC bits above ADDR_W are ignored (wrap)
//  TIMEOUT  255  max consecutive MEM_BUSYWAIT=1 cycles per beat before FETCH_ERR; legal 1..255
// PORTS
//  CLK           in   1       clock; all state updates on rising edge
//  RESET         in   1       synchronous, active-low reset
//  PC            in   32      CPU program counter (byte address)
//  INSTRUCTION   out  32      fetched instruction word for PC
//  BUSYWAIT      out  1       1 = CPU must stall (instruction not valid for current PC)
//  FETCH_ERR     out  1       sticky memory-timeout flag
//  MEM_READ      out  1       byte read request to instruction memory
//  MEM_ADDR      out  ADDR_W  byte address of current read beat
//  MEM_READDATA  in   8       read data; valid on a completing beat
//  MEM_BUSYWAIT  in   1       memory not ready; a beat completes at an edge where MEM_READ=1 and MEM_BUSYWAIT=0
// BEHAVIOUR
//  - Reset (RESET=0 at edge): state=IDLE, INSTRUCTION=32'h0, MEM_READ=0, MEM_ADDR=0, FETCH_ERR=0, beat=0, wait_cnt=0; BUSYWAIT=1.
//  - Word tag = PC[ADDR_W-1:2]; base = {PC[ADDR_W-1:2],2'b00}. PC[1:0] is ignored.
//  - BUSYWAIT is combinational: 0 only when state=VALID and PC word tag == stored tag; 1 otherwise.
//  - States: IDLE, FETCH, VALID, ERROR.
//  - IDLE: first edge with RESET=1 latches base/tag from PC; beat=0; -> FETCH.
//  - FETCH: MEM_READ=1, MEM_ADDR=base+beat (registered, so it is stable throughout the beat).
//    - On a completing beat: INSTRUCTION[8*beat+:8] <= MEM_READDATA; beat++; wait_cnt=0.
//    - After beat 3 completes: -> VALID, MEM_READ=0.
//    - Bytes 0..2 of INSTRUCTION are updated in place during the fetch; the CPU must treat them as invalid while BUSYWAIT=1.
//  - Zero-wait latency: PC change seen in VALID -> 1 edge to FETCH + 4 beat edges; BUSYWAIT low 5 cycles after the PC change.
//  - VALID: INSTRUCTION held stable; no memory traffic.
//    - PC tag mismatch at an edge: latch new base/tag, beat=0, -> FETCH (MEM_READ=1 next cycle).
//  - Redirect mid-fetch: PC tag != stored tag at an edge in FETCH: abort and restart at beat 0 with the new base.
//    - A beat completing at that same edge is discarded (no INSTRUCTION write).
//    - MEM_ADDR switches to the new base the next cycle.
//  - Timeout: wait_cnt counts edges in FETCH with MEM_BUSYWAIT=1; it saturates and clears on beat completion or restart.
//    - wait_cnt reaching TIMEOUT -> ERROR: FETCH_ERR=1, MEM_READ=0, BUSYWAIT=1.
//    - ERROR is left only by reset; PC changes are ignored.
//  - Reset mid-fetch: aborts immediately; no partial word is reported; outputs return to reset values.
//  - PC wrap: base+beat is computed in ADDR_W bits. Base is word-aligned, so beats never cross the top of memory.
// TESTING
//  1. RESET=0 for 2 cycles -> BUSYWAIT=1, MEM_READ=0, MEM_ADDR=0, INSTRUCTION=0, FETCH_ERR=0.
//  2. Release RESET, PC=0, zero-wait memory holding 0x0A,0x00,0x06,0x08 at bytes 0..3
//     -> MEM_ADDR 0,1,2,3 on consecutive cycles; INSTRUCTION=32'h0806000A; BUSYWAIT=0 on the 6th cycle.
//  3. Same fetch, MEM_BUSYWAIT=1 for 2 cycles per beat -> identical INSTRUCTION; BUSYWAIT falls 8 cycles later than in test 2;
//     MEM_ADDR held during waits.
//  4. PC=4 fetch; after beat 1 completes, PC->32 (bytes 0x01,0x00,0x01,0x06)
//     -> MEM_ADDR restarts at 32; INSTRUCTION=32'h06010001; no byte from address 6/7 appears.
//  5. In VALID, PC held for 10 cycles -> MEM_READ stays 0 and BUSYWAIT stays 0;
//     then PC=PC+4 -> BUSYWAIT=1 in the same cycle; a new fetch starts at the next edge.
//  6. TIMEOUT=8, MEM_BUSYWAIT stuck at 1 -> FETCH_ERR=1 after 8 edges; MEM_READ=0; BUSYWAIT=1 while PC changes;
//     RESET=0 clears FETCH_ERR.

Source files
------------

// File: rtl/imem_fetch_ctrl_if.sv
// CPU fetch port plus byte-wide instruction-memory port, as seen by the fetch controller.
// slave = controller view, master = CPU/memory side view.
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic [31:0]       PC;
  logic [31:0]       INSTRUCTION;
  logic              BUSYWAIT;
  logic              FETCH_ERR;
  logic              MEM_READ;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [7:0]        MEM_READDATA;
  logic              MEM_BUSYWAIT;

  modport slave (
    input  PC, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, FETCH_ERR, MEM_READ, MEM_ADDR
  );

  modport master (
    output PC, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, FETCH_ERR, MEM_READ, MEM_ADDR
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetches a 32-bit word as four little-endian byte beats; 1 edge + 4 beats at zero wait.
// Stalls the CPU via BUSYWAIT until the word matches PC; MEM_BUSYWAIT holds the current beat.
module imem_fetch_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input logic            CLK,
  input logic            RESET,
  imem_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, ERROR} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            r_state, w_state;
  logic [ADDR_W-3:0] r_tag, w_tag;
  logic [1:0]        r_beat, w_beat;
  logic [7:0]        r_wait_cnt, w_wait_cnt;
  logic [31:0]       r_instr, w_instr;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;

  logic [ADDR_W-3:0] w_pc_tag;
  logic              w_tag_hit;
  logic [7:0]        w_wait_inc;
  logic              w_unused_pc;

  assign w_pc_tag    = bus.PC[ADDR_W-1:2];
  assign w_tag_hit   = (w_pc_tag == r_tag);
  assign w_wait_inc  = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;
  assign w_unused_pc = &{1'b0, bus.PC[31:ADDR_W], bus.PC[1:0]};

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state    <= IDLE;
      r_tag      <= '0;
      r_beat     <= 2'd0;
      r_wait_cnt <= 8'd0;
      r_instr    <= 32'h0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state;
      r_tag      <= w_tag;
      r_beat     <= w_beat;
      r_wait_cnt <= w_wait_cnt;
      r_instr    <= w_instr;
      r_mem_addr <= w_mem_addr;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_tag      = r_tag;
    w_beat     = r_beat;
    w_wait_cnt = r_wait_cnt;
    w_instr    = r_instr;
    w_mem_addr = r_mem_addr;
    unique case (r_state)
      IDLE: begin
        w_tag      = w_pc_tag;
        w_beat     = 2'd0;
        w_wait_cnt = 8'd0;
        w_mem_addr = {w_pc_tag, 2'b00};
        w_state    = FETCH;
      end
      FETCH: begin
        // A redirect wins over a beat completing at the same edge, so the stale byte is dropped.
        if (!w_tag_hit) begin
          w_tag      = w_pc_tag;
          w_beat     = 2'd0;
          w_wait_cnt = 8'd0;
          w_mem_addr = {w_pc_tag, 2'b00};
        end else if (!bus.MEM_BUSYWAIT) begin
          w_instr[8*r_beat +: 8] = bus.MEM_READDATA;
          w_wait_cnt             = 8'd0;
          if (r_beat == 2'd3) begin
            w_state = VALID;
          end else begin
            w_beat     = r_beat + 2'd1;
            w_mem_addr = {r_tag, r_beat + 2'd1};
          end
        end else begin
          w_wait_cnt = w_wait_inc;
          if (w_wait_inc == TIMEOUT_C) w_state = ERROR;
        end
      end
      VALID: begin
        if (!w_tag_hit) begin
          w_tag      = w_pc_tag;
          w_beat     = 2'd0;
          w_wait_cnt = 8'd0;
          w_mem_addr = {w_pc_tag, 2'b00};
          w_state    = FETCH;
        end
      end
      ERROR: w_state = ERROR;
      default: w_state = IDLE;
    endcase
  end

  assign bus.INSTRUCTION = r_instr;
  assign bus.MEM_ADDR    = r_mem_addr;
  assign bus.MEM_READ    = (r_state == FETCH);
  assign bus.FETCH_ERR   = (r_state == ERROR);
  assign bus.BUSYWAIT    = !((r_state == VALID) && w_tag_hit);

endmodule
